// File: rtl/lane_map_arb_if.sv
// Requester and response bundle between the lane_map_arb arbiter and the datapaths it serves.
interface lane_map_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 9,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/lane_map_arb.sv
// Round-robin arbiter sharing one combinational lane-map unit between NREQ requesters.
// Optional LANE_MAP_ARB_SIG_EN adds a 32-bit response signature (sig_clr / sig_out).
module lane_map_arb #(
    parameter int NREQ = 4,
    parameter int W    = 9,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic          clk,
    input  logic          rst,
    lane_map_arb_if.slave bus,
    output logic [W-1:0]  map_in,
    input  logic [W-1:0]  map_out,
    output logic          busy
`ifdef LANE_MAP_ARB_SIG_EN
    ,
    input  logic          sig_clr,
    output logic [31:0]   sig_out
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gsel;
    logic            found;
    logic [NREQ-1:0] rot;
    logic [IDW:0]    sum;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    gdata;

    // Rotate requests so bit 0 is the pointer position; first set bit is the winner.
    always_comb begin
        rot   = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
        found = 1'b0;
        gsel  = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDW+1)'(i);
                if (sum >= (IDW+1)'(NREQ))
                    sum = sum - (IDW+1)'(NREQ);
                gsel  = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        gnt   = '0;
        gdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gsel == IDW'(k)) begin
                gnt[k] = found;
                gdata  = bus.req_data[k*W +: W];
            end
        end
        bus.req_ready = (state == IDLE && !rst) ? gnt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            map_in        <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        map_in     <= gdata;
                        bus.rsp_id <= gsel;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.rsp_data  <= map_out;
                    bus.rsp_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        ptr           <= (bus.rsp_id == IDW'(NREQ-1)) ? '0 : bus.rsp_id + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef LANE_MAP_ARB_SIG_EN
    logic [31:0] sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= '0;
        else if (sig_clr)
            sig <= '0;
        else if (state == HOLD && bus.rsp_ready)
            sig <= {sig[30:0], sig[31]} ^ {{(32-W){1'b0}}, bus.rsp_data};
    end

    assign sig_out = sig;
`endif
endmodule

// File: tb/tb_lane_map_arb.sv
// Directed bench for lane_map_arb with a response scoreboard; lane-map model is map_in ^ 9'h1FF.
module tb_lane_map_arb;
    localparam int NREQ = 4;
    localparam int W    = 9;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   map_in;
    logic [W-1:0]   map_out;
    logic           busy;
    logic [W-1:0]   word [NREQ];
    exp_t           sb [$];
    int             tests = 0;
    int             fails = 0;
`ifdef LANE_MAP_ARB_SIG_EN
    logic           sig_clr;
    logic [31:0]    sig_out;
`endif

    lane_map_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    lane_map_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .map_in  (map_in),
        .map_out (map_out),
        .busy    (busy)
`ifdef LANE_MAP_ARB_SIG_EN
        ,
        .sig_clr (sig_clr),
        .sig_out (sig_out)
`endif
    );

    assign map_out = map_in ^ 9'h1FF;

    always_comb begin
        for (int k = 0; k < NREQ; k++)
            bus.req_data[k*W +: W] = word[k];
    end

    always #5 clk = ~clk;

    `define CHK(tag, obs, exp) \
        begin \
            tests++; \
            assert ((obs) === (exp)) else begin \
                fails++; \
                $error("FAIL %s: observed %0h, expected %0h", tag, (obs), (exp)); \
            end \
        end

    task automatic push_exp(input int g);
        exp_t e;
        e.id   = IDW'(g);
        e.data = word[g] ^ 9'h1FF;
        sb.push_back(e);
    endtask

    // Scoreboard: every response handshake pops the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_underflow: observed response id %0h data %0h, expected none", bus.rsp_id, bus.rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                `CHK("sb_id", bus.rsp_id, e.id)
                `CHK("sb_data", bus.rsp_data, e.data)
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10);
        if (busy) begin
            tests++;
            fails++;
            $error("FAIL idle_timeout: observed busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    // One single-requester transaction; clr asserts sig_clr on the handshake cycle.
    task automatic txn(input int g, input logic [W-1:0] w, input logic clr);
        int n;
        word[g]       = w;
        bus.req_valid = NREQ'(1 << g);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        `CHK("txn_grant", bus.req_ready, NREQ'(1 << g))
        push_exp(g);
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 8);
        `CHK("txn_rsp_valid", bus.rsp_valid, 1'b1)
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
`ifdef LANE_MAP_ARB_SIG_EN
        sig_clr = clr;
`endif
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
`ifdef LANE_MAP_ARB_SIG_EN
        sig_clr = 1'b0;
`endif
        @(negedge clk);
        `CHK("txn_idle", busy, 1'b0)
        if (clr) begin end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int g;
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        word[0] = 9'h1C3;
        word[1] = 9'h012;
        word[2] = 9'h0A5;
        word[3] = 9'h155;
`ifdef LANE_MAP_ARB_SIG_EN
        sig_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        `CHK("rst_req_ready", bus.req_ready, 4'b0000)
        `CHK("rst_rsp_valid", bus.rsp_valid, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_rsp_id", bus.rsp_id, 2'd0)
        `CHK("rst_rsp_data", bus.rsp_data, 9'h000)
        `CHK("rst_map_in", map_in, 9'h000)

        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        `CHK("idle_no_req", bus.req_ready, 4'b0000)

        // Single request from requester 2: grant, then response two cycles later.
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        `CHK("t2_grant", bus.req_ready, 4'b0100)
        push_exp(2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        `CHK("t2_issue_valid", bus.rsp_valid, 1'b0)
        `CHK("t2_issue_busy", busy, 1'b1)
        `CHK("t2_map_in", map_in, 9'h0A5)
        @(posedge clk); #1;
        bus.req_valid = '1;
        @(negedge clk);
        `CHK("t2_rsp_valid", bus.rsp_valid, 1'b1)
        `CHK("t2_rsp_id", bus.rsp_id, 2'd2)
        `CHK("t2_rsp_data", bus.rsp_data, 9'h15A)

        // Back-pressure in HOLD: outputs stable, no grants despite pending requests.
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            `CHK("t4_hold_valid", bus.rsp_valid, 1'b1)
            `CHK("t4_hold_id", bus.rsp_id, 2'd2)
            `CHK("t4_hold_data", bus.rsp_data, 9'h15A)
            `CHK("t4_hold_ready", bus.req_ready, 4'b0000)
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        `CHK("t4_idle", busy, 1'b0)
        `CHK("t4_ptr_grant", bus.req_ready, 4'b1000)
        push_exp(3);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Reset while requester 1 is in HOLD drops it and clears the pointer.
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        `CHK("t5_grant1", bus.req_ready, 4'b0010)
        @(posedge clk); #1;
        bus.req_valid = '1;
        @(posedge clk); #1;
        @(negedge clk);
        `CHK("t5_hold_valid", bus.rsp_valid, 1'b1)
        `CHK("t5_hold_id", bus.rsp_id, 2'd1)
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        `CHK("t5_rst_valid", bus.rsp_valid, 1'b0)
        `CHK("t5_rst_busy", busy, 1'b0)
        `CHK("t5_rst_ready", bus.req_ready, 4'b0000)
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        `CHK("t5_first_grant", bus.req_ready, 4'b0001)
        push_exp(0);

        // All requesters pending: rotation 1,2,3,0, each grant three cycles apart.
        for (int k = 1; k <= 4; k++) begin
            g   = k % NREQ;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.req_ready == '0 && cyc < 8);
            `CHK("t3_gap", cyc, 3)
            `CHK("t3_grant", bus.req_ready, NREQ'(1 << g))
            push_exp(g);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

`ifdef LANE_MAP_ARB_SIG_EN
        @(posedge clk); #1;
        sig_clr = 1'b1;
        @(posedge clk); #1;
        sig_clr = 1'b0;
        @(negedge clk);
        `CHK("sig_clr", sig_out, 32'h0)
        @(posedge clk); #1;
        txn(0, 9'h1FE, 1'b0);
        `CHK("sig_first", sig_out, 32'h0000_0001)
        @(posedge clk); #1;
        txn(1, 9'h0FF, 1'b0);
        `CHK("sig_second", sig_out, 32'h0000_0102)
        @(posedge clk); #1;
        txn(2, 9'h000, 1'b1);
        `CHK("sig_clr_priority", sig_out, 32'h0)
`else
        @(posedge clk); #1;
        txn(1, 9'h0FF, 1'b0);
`endif

        repeat (3) @(negedge clk);
        `CHK("sb_drained", sb.size(), 0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
